// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase-aligned restart.
// New settings take effect only after every running channel has finished its current period.
module clk_div_gen #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned RST_DIV   = 4
) (
    input  logic                            BUS_CLK,
    input  logic                            BUS_RST,
    input  logic [CHANNELS-1:0]             EN,
    input  logic [CHANNELS*DIV_WIDTH-1:0]   DIV_IN,
    input  logic [CHANNELS*DIV_WIDTH-1:0]   PHASE_IN,
    input  logic                            LOAD,
    output logic [CHANNELS-1:0]             CLK_OUT,
    output logic [CHANNELS-1:0]             CE_OUT,
    output logic                            READY
);

    typedef enum logic [1:0] {StStart, StRun, StDrain} state_e;
    typedef logic [CHANNELS-1:0][DIV_WIDTH-1:0] field_t;

    localparam logic [DIV_WIDTH-1:0] RstDiv = DIV_WIDTH'(RST_DIV);
    localparam logic [DIV_WIDTH-1:0] One    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] Two    = DIV_WIDTH'(2);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    field_t              sh_div_q, sh_div_d, sh_ph_q, sh_ph_d;
    field_t              act_div_q, act_div_d, act_ph_q, act_ph_d;
    field_t              cnt_q, cnt_d;
    logic [CHANNELS-1:0] run_q, run_d, clk_q, clk_d, ce_q, ce_d;

    field_t start_div, start_ph, cnt_inc;
    logic   stop_req;

    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
        return (div >= Two) ? div : Two;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] eff_phase(input logic [DIV_WIDTH-1:0] ph,
                                                       input logic [DIV_WIDTH-1:0] div);
        return (ph < div) ? ph : '0;
    endfunction

    // Draining begins on the very edge LOAD arrives in RUN.
    assign stop_req = (state_q == StDrain) || ((state_q == StRun) && LOAD);

    always_comb begin
        start_div = '0;
        start_ph  = '0;
        cnt_inc   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            start_div[i] = eff_div(sh_div_q[i]);
            start_ph[i]  = eff_phase(sh_ph_q[i], start_div[i]);
            cnt_inc[i]   = cnt_q[i] + One;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        sh_div_d  = LOAD ? DIV_IN : sh_div_q;
        sh_ph_d   = LOAD ? PHASE_IN : sh_ph_q;
        act_div_d = act_div_q;
        act_ph_d  = act_ph_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        clk_d     = clk_q;
        ce_d      = ce_q;

        unique case (state_q)
            StStart: begin
                if (LOAD) begin
                    state_d = StDrain;
                end else begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                if (LOAD) begin
                    state_d = StDrain;
                    ready_d = 1'b0;
                end
            end
            StDrain: begin
                if (!LOAD && (run_q == '0)) state_d = StStart;
            end
            default: state_d = StStart;
        endcase

        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (state_q == StStart) begin
                if (!LOAD) begin
                    act_div_d[i] = start_div[i];
                    act_ph_d[i]  = start_ph[i];
                    run_d[i]     = EN[i];
                    cnt_d[i]     = EN[i] ? start_ph[i] : '0;
                    clk_d[i]     = EN[i] && (start_ph[i] < (start_div[i] >> 1));
                    ce_d[i]      = EN[i] && (start_ph[i] == '0);
                end
            end else if (run_q[i]) begin
                if (cnt_q[i] == act_div_q[i] - One) begin
                    // End of period: either stop cleanly or wrap into a new high phase.
                    run_d[i] = !(stop_req || !EN[i]);
                    cnt_d[i] = '0;
                    clk_d[i] = run_d[i];
                    ce_d[i]  = run_d[i];
                end else begin
                    cnt_d[i] = cnt_inc[i];
                    clk_d[i] = cnt_inc[i] < (act_div_q[i] >> 1);
                    ce_d[i]  = 1'b0;
                end
            end else if ((state_q == StRun) && !LOAD && EN[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = act_ph_q[i];
                clk_d[i] = act_ph_q[i] < (act_div_q[i] >> 1);
                ce_d[i]  = act_ph_q[i] == '0;
            end else begin
                clk_d[i] = 1'b0;
                ce_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q   <= StStart;
            ready_q   <= 1'b0;
            sh_div_q  <= {CHANNELS{RstDiv}};
            sh_ph_q   <= '0;
            act_div_q <= {CHANNELS{RstDiv}};
            act_ph_q  <= '0;
            cnt_q     <= '0;
            run_q     <= '0;
            clk_q     <= '0;
            ce_q      <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            sh_div_q  <= sh_div_d;
            sh_ph_q   <= sh_ph_d;
            act_div_q <= act_div_d;
            act_ph_q  <= act_ph_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            clk_q     <= clk_d;
            ce_q      <= ce_d;
        end
    end

    assign CLK_OUT = clk_q;
    assign CE_OUT  = ce_q;
    assign READY   = ready_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen with default parameters (3 channels, 8-bit fields).
module tb_clk_div_gen;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic [2:0]  EN;
    logic [23:0] DIV_IN;
    logic [23:0] PHASE_IN;
    logic        LOAD;
    logic [2:0]  CLK_OUT;
    logic [2:0]  CE_OUT;
    logic        READY;

    int n_cmp;
    int n_err;

    clk_div_gen dut (
        .BUS_CLK (BUS_CLK),
        .BUS_RST (BUS_RST),
        .EN      (EN),
        .DIV_IN  (DIV_IN),
        .PHASE_IN(PHASE_IN),
        .LOAD    (LOAD),
        .CLK_OUT (CLK_OUT),
        .CE_OUT  (CE_OUT),
        .READY   (READY)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic load_cfg(input logic [23:0] div, input logic [23:0] ph);
        DIV_IN   = div;
        PHASE_IN = ph;
        LOAD     = 1'b1;
        tick();
        LOAD     = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (!READY && i < 40) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(READY), 32'd1);
    endtask

    // Cycle k after a start: count = (k+P) mod D, high while count < D/2.
    function automatic logic exp_hi(input int k, input int d, input int p);
        return ((k + p) % d) < (d / 2);
    endfunction

    function automatic logic exp_ce(input int k, input int d, input int p);
        return ((k + p) % d) == 0;
    endfunction

    task automatic run_check(input string tag, input int n, input int d0, input int p0,
                             input int d1, input int p1, input int d2, input int p2);
        logic [2:0] ec;
        logic [2:0] ee;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            ec = {exp_hi(k, d2, p2), exp_hi(k, d1, p1), exp_hi(k, d0, p0)};
            ee = {exp_ce(k, d2, p2), exp_ce(k, d1, p1), exp_ce(k, d0, p0)};
            check_eq($sformatf("%s_clk_k%0d", tag, k), 32'(CLK_OUT), 32'(ec));
            check_eq($sformatf("%s_ce_k%0d", tag, k), 32'(CE_OUT), 32'(ee));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        BUS_RST  = 1'b1;
        EN       = 3'b111;
        LOAD     = 1'b0;
        DIV_IN   = '0;
        PHASE_IN = '0;

        tick();
        check_eq("rst_clk", 32'(CLK_OUT), 32'd0);
        check_eq("rst_ce", 32'(CE_OUT), 32'd0);
        check_eq("rst_ready", 32'(READY), 32'd0);

        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        tick();
        check_eq("start_ready", 32'(READY), 32'd1);
        run_check("div4", 5, 4, 0, 4, 0, 4, 0);

        // LOAD while every channel is at count 0: the high phase must complete.
        load_cfg({8'd5, 8'd3, 8'd6}, 24'd0);
        check_eq("drain_hi_clk", 32'(CLK_OUT), 32'h7);
        check_eq("drain_hi_ce", 32'(CE_OUT), 32'd0);
        check_eq("drain_ready", 32'(READY), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check_eq($sformatf("drain_gap_clk%0d", j), 32'(CLK_OUT), 32'd0);
            check_eq($sformatf("drain_gap_ready%0d", j), 32'(READY), 32'd0);
        end
        tick();
        check_eq("restart_ready", 32'(READY), 32'd1);
        run_check("div653", 30, 6, 0, 3, 0, 5, 0);

        load_cfg({8'd4, 8'd4, 8'd4}, {8'd0, 8'd2, 8'd0});
        wait_ready("phase_ready");
        run_check("phase", 12, 4, 0, 4, 2, 4, 0);

        load_cfg({8'd0, 8'd1, 8'd4}, {8'd9, 8'd9, 8'd9});
        wait_ready("clamp_ready");
        run_check("clamp", 9, 4, 0, 2, 0, 2, 0);

        // Two LOADs back to back; restart must use the second set.
        load_cfg({8'd6, 8'd6, 8'd6}, 24'd0);
        check_eq("dbl_a_clk", 32'(CLK_OUT), 32'h1);
        check_eq("dbl_a_ready", 32'(READY), 32'd0);
        load_cfg({8'd7, 8'd5, 8'd3}, {8'd0, 8'd0, 8'd1});
        check_eq("dbl_b_clk", 32'(CLK_OUT), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq($sformatf("dbl_gap_clk%0d", j), 32'(CLK_OUT), 32'd0);
            check_eq($sformatf("dbl_gap_ready%0d", j), 32'(READY), 32'd0);
        end
        tick();
        check_eq("dbl_ready", 32'(READY), 32'd1);
        run_check("dbl_run", 16, 3, 1, 5, 0, 7, 0);

        // ch1 is at count 0 (high); dropping EN must not truncate the high phase.
        EN = 3'b101;
        for (int j = 0; j < 7; j++) begin
            tick();
            check_eq($sformatf("enoff_clk%0d", j), 32'(CLK_OUT[1]), (j == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("enoff_ce%0d", j), 32'(CE_OUT[1]), 32'd0);
        end
        check_eq("enoff_ready", 32'(READY), 32'd1);
        EN = 3'b111;
        tick();
        check_eq("enon_clk0", 32'(CLK_OUT[1]), 32'd1);
        check_eq("enon_ce0", 32'(CE_OUT[1]), 32'd1);
        tick();
        check_eq("enon_clk1", 32'(CLK_OUT[1]), 32'd1);
        check_eq("enon_ce1", 32'(CE_OUT[1]), 32'd0);
        tick();
        check_eq("enon_clk2", 32'(CLK_OUT[1]), 32'd0);
        check_eq("enon_ready", 32'(READY), 32'd1);

        tick();
        tick();
        tick();
        load_cfg({8'd9, 8'd9, 8'd9}, 24'd0);
        check_eq("rst_drain_clk", 32'(CLK_OUT), 32'h6);
        check_eq("rst_drain_ready", 32'(READY), 32'd0);

        // Asynchronous reset between edges.
        #3;
        BUS_RST = 1'b1;
        #1;
        check_eq("async_rst_clk", 32'(CLK_OUT), 32'd0);
        check_eq("async_rst_ce", 32'(CE_OUT), 32'd0);
        check_eq("async_rst_ready", 32'(READY), 32'd0);
        tick();
        check_eq("rst_hold_clk", 32'(CLK_OUT), 32'd0);
        check_eq("rst_hold_ready", 32'(READY), 32'd0);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(READY), 32'd1);
        run_check("post_rst", 8, 4, 0, 4, 0, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent divided-clock channels.
REQ-002 SHALL have parameter DIV_WIDTH, default 8: width of each divisor and phase field.
REQ-003 SHALL have parameter RST_DIV, default 4: divisor loaded into every channel at reset.
REQ-004 SHALL have port BUS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port BUS_RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port EN  in  CHANNELS  per-channel run enable.
REQ-007 SHALL have port DIV_IN  in  CHANNELS*DIV_WIDTH  requested divisor per channel; channel i at bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-008 SHALL have port PHASE_IN  in  CHANNELS*DIV_WIDTH  requested start count per channel, same packing.
REQ-009 SHALL have port LOAD  in  1  single-cycle strobe capturing DIV_IN/PHASE_IN.
REQ-010 SHALL have port CLK_OUT  out  CHANNELS  registered divided clocks.
REQ-011 SHALL have port CE_OUT  out  CHANNELS  registered one-cycle pulse per period, coincident with CLK_OUT rising.
REQ-012 SHALL have port READY  out  1  high when all channels run with the latest loaded settings.

Function
REQ-013 Effective divisor D SHALL be DIV if DIV>=2, else 2; effective phase P SHALL be PHASE if PHASE<D, else 0.
REQ-014 Each channel SHALL hold active D, P and counter cnt (DIV_WIDTH bits); LOAD SHALL capture DIV_IN/PHASE_IN into shadow registers on the same edge.
REQ-015 In RUN, an enabled channel SHALL step cnt to 0 when cnt==D-1, else cnt+1.
REQ-016 Every update of cnt SHALL set CLK_OUT to (new cnt < D>>1) and CE_OUT to (new cnt == 0); odd D gives high floor(D/2), low ceil(D/2) cycles.
REQ-017 State machine SHALL have states START, RUN, DRAIN.
REQ-018 START: on the next edge every enabled channel SHALL load active settings from shadow, set cnt=P, and set outputs per REQ-016; state -> RUN; READY -> 1.
REQ-019 RUN: LOAD SHALL move state to DRAIN and set READY=0 on the same edge.
REQ-020 DRAIN: a running channel SHALL keep counting until it reaches cnt==D-1, then stop with cnt=0, CLK_OUT=0, CE_OUT=0.
REQ-021 DRAIN: once all channels are stopped or disabled, state SHALL go to START on the next edge.
REQ-022 LOAD during DRAIN or START SHALL recapture shadow and leave or enter DRAIN; the final restart SHALL use the last captured values.
REQ-023 EN falling SHALL let the channel finish its current period, then stop as in REQ-020; it SHALL never truncate a high phase.
REQ-024 EN rising in RUN SHALL start that channel on the next edge at cnt=P of its active settings; READY SHALL be unaffected.
REQ-025 A stopped or disabled channel SHALL drive CLK_OUT=0 and CE_OUT=0.
REQ-026 A CLK_OUT high pulse SHALL never be shorter than floor(D/2) cycles of the active D.
REQ-027 After a restart all channels with equal D and P SHALL be cycle-aligned.

Reset
REQ-028 BUS_RST SHALL immediately force CLK_OUT=0, CE_OUT=0, READY=0, cnt=0, active/shadow D=RST_DIV, P=0, and state START, regardless of clock.
REQ-029 The first edge after BUS_RST falls SHALL execute START per REQ-018.

Verification
REQ-030 Reset release, EN=3'b111, defaults -> READY=1 after 1 edge; each CLK_OUT high 2 / low 2, CE_OUT every 4th cycle, all aligned.
REQ-031 LOAD, DIV_IN={5,3,6}, PHASE 0 -> READY low, each channel completes its period, then restart; ch0 high 3/low 3, ch1 high 1/low 2, ch2 high 2/low 3; READY=1.
REQ-032 D=4 both channels, ch0 P=0, ch1 P=2 -> ch1 CLK_OUT is the inverse of ch0; CE_OUT offset by 2 cycles.
REQ-033 DIV_IN=0 and 1, PHASE_IN=9 with D=4 -> divide by 2, start count 0.
REQ-034 Second LOAD mid-DRAIN -> single restart using the second values; no high pulse shorter than floor(D/2).
REQ-035 BUS_RST asserted mid-DRAIN between edges -> outputs 0 with no edge; after release, RST_DIV operation per REQ-030.
